// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit memory, decode and redirect bundle
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [31:0]           imem_rdata;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [31:0]           instr;
  logic [5:0]            opcode;
  logic [ADDR_WIDTH-1:0] pc_out;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, pc_out,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC owner, req/ack fetch, instruction register with redirect squash
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_unit_if.master  bus
);
  typedef enum logic {ST_REQ, ST_VALID} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]           instr_q, instr_d;
  logic                  squash_q, squash_d;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  assign redirect_pc = bus.branch_target & ~ADDR_WIDTH'(3);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    squash_d = squash_q;
    case (state_q)
      ST_REQ: begin
        if (bus.branch_taken) begin
          pc_d = redirect_pc;
          // Without a same-cycle ack the old request is still owed a response.
          squash_d = !bus.imem_ack;
        end else if (bus.imem_ack) begin
          if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            instr_d  = bus.imem_rdata;
            pc_out_d = pc_q;
            pc_d     = pc_q + ADDR_WIDTH'(4);
            state_d  = ST_VALID;
          end
        end
      end
      ST_VALID: begin
        if (bus.branch_taken) begin
          pc_d    = redirect_pc;
          state_d = ST_REQ;
        end else if (bus.instr_ready) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      pc_out_q <= '0;
      instr_q  <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      squash_q <= squash_d;
    end
  end

  // Gated by reset so memory never sees a request while reset is held.
  assign bus.imem_req    = (state_q == ST_REQ) && !reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == ST_VALID);
  assign bus.instr       = instr_q;
  assign bus.opcode      = instr_q[31:26];
  assign bus.pc_out      = pc_out_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized and directed checks of instr_fetch_unit
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst, rst8;
  int   n_checks = 0;
  int   n_fail = 0;

  bit          mem_const, mem_rand, busy;
  int          mem_lat, left;
  logic [31:0] req_addr;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_WIDTH(32)) bus ();
  instr_fetch_unit_if #(.ADDR_WIDTH(8))  bus8 ();

  instr_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h100)) dut (.clk(clk), .reset(rst), .bus(bus));
  instr_fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'hFC)) dut8 (.clk(clk), .reset(rst8), .bus(bus8));

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_const) return 32'h8C01_0004;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Memory model: latches the address when a request starts, answers after 'left' cycles.
  task automatic tick();
    @(negedge clk);
    bus.branch_taken = 1'b0;
    if (rst) begin
      busy = 1'b0;
      bus.imem_ack = 1'b0;
      bus.imem_rdata = $urandom;
    end else begin
      if (!busy && bus.imem_req) begin
        busy = 1'b1;
        req_addr = bus.imem_addr;
        left = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      end
      if (busy && left == 0) begin
        bus.imem_ack = 1'b1;
        bus.imem_rdata = mem_word(req_addr);
        busy = 1'b0;
      end else begin
        bus.imem_ack = 1'b0;
        bus.imem_rdata = $urandom;
        if (busy) left--;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.instr_ready = 1'b0;
    bus.branch_target = '0;
    mem_rand = 1'b0;
    mem_const = 1'b0;
    mem_lat = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", bus.imem_req); end
    n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.instr_valid); end
    n_checks++; if (bus.instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 0", bus.instr); end
    n_checks++; if (bus.opcode !== 6'h0) begin n_fail++; $display("FAIL reset_opcode got %h exp 0", bus.opcode); end
    n_checks++; if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc_out got %h exp 0", bus.pc_out); end
    rst = 1'b0;
    #1;
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL post_reset_req got %b exp 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL post_reset_addr got %h exp 100", bus.imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    mem_const = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (bus.instr_valid !== (i % 2 == 1)) begin n_fail++; $display("FAIL stream_valid[%0d] got %b exp %b", i, bus.instr_valid, (i % 2 == 1)); end
      n_checks++; if (bus.imem_req !== (i % 2 == 0)) begin n_fail++; $display("FAIL stream_req[%0d] got %b exp %b", i, bus.imem_req, (i % 2 == 0)); end
      if (i % 2 == 0) begin
        n_checks++; if (bus.imem_addr !== 32'h100 + 32'(4 * (i / 2))) begin n_fail++; $display("FAIL stream_addr[%0d] got %h exp %h", i, bus.imem_addr, 32'h100 + 32'(4 * (i / 2))); end
      end else begin
        n_checks++; if (bus.pc_out !== 32'h100 + 32'(4 * (i / 2))) begin n_fail++; $display("FAIL stream_pc_out[%0d] got %h exp %h", i, bus.pc_out, 32'h100 + 32'(4 * (i / 2))); end
        n_checks++; if (bus.opcode !== 6'b100011) begin n_fail++; $display("FAIL stream_opcode[%0d] got %b exp 100011", i, bus.opcode); end
        n_checks++; if (bus.instr !== 32'h8C01_0004) begin n_fail++; $display("FAIL stream_instr[%0d] got %h exp 8c010004", i, bus.instr); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] s_instr, s_pc;
    logic [5:0]  s_op;
    bit          found = 1'b0;
    apply_reset();
    for (int w = 0; w < 10 && !found; w++) begin
      tick();
      found = bus.instr_valid;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL bp_valid_timeout got 0 exp 1"); end
    s_instr = bus.instr; s_pc = bus.pc_out; s_op = bus.opcode;
    n_checks++; if (s_pc !== 32'h100) begin n_fail++; $display("FAIL bp_pc_out got %h exp 100", s_pc); end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] got valid %b req %b exp 1 0", k, bus.instr_valid, bus.imem_req); end
      n_checks++; if (bus.instr !== s_instr || bus.pc_out !== s_pc || bus.opcode !== s_op) begin n_fail++; $display("FAIL bp_stable[%0d] got %h/%h/%h exp %h/%h/%h", k, bus.instr, bus.pc_out, bus.opcode, s_instr, s_pc, s_op); end
      if (k == 4) bus.instr_ready = 1'b1;
    end
    tick();
    n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL bp_release got valid %b req %b exp 0 1", bus.instr_valid, bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 32'h104) begin n_fail++; $display("FAIL bp_next_addr got %h exp 104", bus.imem_addr); end
  endtask

  task automatic test_wait_states();
    apply_reset();
    mem_lat = 3;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL wait_req[%0d] got %b %h exp 1 100", c, bus.imem_req, bus.imem_addr); end
      n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid[%0d] got %b exp 0", c, bus.instr_valid); end
    end
    tick();
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL wait_latency got %b exp 1", bus.instr_valid); end
    n_checks++; if (bus.instr !== mem_word(32'h100) || bus.pc_out !== 32'h100) begin n_fail++; $display("FAIL wait_data got %h/%h exp %h/100", bus.instr, bus.pc_out, mem_word(32'h100)); end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    mem_lat = 4;
    bus.instr_ready = 1'b1;
    tick();
    mem_lat = 0;
    tick();
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h203;
    for (int c = 2; c < 6; c++) begin
      tick();
      n_checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL rw_addr[%0d] got %b %h exp 1 200", c, bus.imem_req, bus.imem_addr); end
      n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_squash[%0d] got %b exp 0", c, bus.instr_valid); end
    end
    tick();
    n_checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL rw_deliver got %b %h exp 1 200", bus.instr_valid, bus.pc_out); end
    n_checks++; if (bus.instr !== mem_word(32'h200)) begin n_fail++; $display("FAIL rw_instr got %h exp %h", bus.instr, mem_word(32'h200)); end
  endtask

  task automatic test_redirect_valid();
    apply_reset();
    tick();
    tick();
    n_checks++; if (bus.instr_valid !== 1'b1) begin n_fail++; $display("FAIL rv_setup got %b exp 1", bus.instr_valid); end
    for (int r = 0; r < 2; r++) begin
      bus.instr_ready = (r == 1);
      bus.branch_taken = 1'b1;
      bus.branch_target = (r == 0) ? 32'h41 : 32'h82;
      tick();
      n_checks++; if (bus.instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rv_drop[%0d] got valid %b req %b exp 0 1", r, bus.instr_valid, bus.imem_req); end
      n_checks++; if (bus.imem_addr !== ((r == 0) ? 32'h40 : 32'h80)) begin n_fail++; $display("FAIL rv_target[%0d] got %h exp %h", r, bus.imem_addr, (r == 0) ? 32'h40 : 32'h80); end
      bus.instr_ready = 1'b0;
      tick();
      n_checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== ((r == 0) ? 32'h40 : 32'h80)) begin n_fail++; $display("FAIL rv_fetch[%0d] got %b %h exp 1 %h", r, bus.instr_valid, bus.pc_out, (r == 0) ? 32'h40 : 32'h80); end
    end
  endtask

  task automatic test_wrap_and_async_reset();
    @(negedge clk);
    rst8 = 1'b0;
    @(negedge clk);
    n_checks++; if (bus8.imem_req !== 1'b1 || bus8.imem_addr !== 8'hFC) begin n_fail++; $display("FAIL wrap_first got %b %h exp 1 fc", bus8.imem_req, bus8.imem_addr); end
    bus8.imem_ack = 1'b1;
    bus8.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus8.imem_ack = 1'b0;
    n_checks++; if (bus8.instr_valid !== 1'b1 || bus8.pc_out !== 8'hFC) begin n_fail++; $display("FAIL wrap_valid got %b %h exp 1 fc", bus8.instr_valid, bus8.pc_out); end
    bus8.instr_ready = 1'b1;
    @(negedge clk);
    bus8.instr_ready = 1'b0;
    n_checks++; if (bus8.imem_req !== 1'b1 || bus8.imem_addr !== 8'h00) begin n_fail++; $display("FAIL wrap_addr got %b %h exp 1 00", bus8.imem_req, bus8.imem_addr); end
    @(negedge clk);
    #2;
    rst8 = 1'b1;
    #1;
    n_checks++; if (bus8.imem_req !== 1'b0 || bus8.instr_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_ctl got req %b valid %b exp 0 0", bus8.imem_req, bus8.instr_valid); end
    n_checks++; if (bus8.instr !== 32'h0 || bus8.opcode !== 6'h0 || bus8.pc_out !== 8'h0) begin n_fail++; $display("FAIL async_rst_regs got %h %h %h exp 0 0 0", bus8.instr, bus8.opcode, bus8.pc_out); end
    n_checks++; if (bus8.imem_addr !== 8'hFC) begin n_fail++; $display("FAIL async_rst_pc got %h exp fc", bus8.imem_addr); end
  endtask

  // Reference: instructions must reach decode in program order from the last redirect target.
  task automatic test_random();
    logic [31:0] exp_pc, p_instr, p_pcout, p_addr, p_target;
    bit          p_valid, p_req, p_ack, p_hs, p_br, rdy, br;
    int          delivered = 0;
    apply_reset();
    mem_rand = 1'b1;
    exp_pc = 32'h100;
    {p_valid, p_req, p_ack, p_hs, p_br} = '0;
    p_instr = '0; p_pcout = '0; p_addr = '0; p_target = '0;
    for (int i = 0; i < 600; i++) begin
      tick();
      n_checks++; if (bus.imem_req !== !bus.instr_valid) begin n_fail++; $display("FAIL rnd_req_xor_valid[%0d] got %b %b", i, bus.imem_req, bus.instr_valid); end
      if (bus.instr_valid && !p_valid) begin
        n_checks++; if (!(p_ack && !p_br)) begin n_fail++; $display("FAIL rnd_latency[%0d] got prev ack %b br %b exp 1 0", i, p_ack, p_br); end
      end
      if (p_br) begin
        n_checks++; if (bus.imem_addr !== (p_target & ~32'h3) || bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect[%0d] got %h %b exp %h 0", i, bus.imem_addr, bus.instr_valid, p_target & ~32'h3); end
      end else if (p_hs) begin
        n_checks++; if (bus.instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_accept_drop[%0d] got %b exp 0", i, bus.instr_valid); end
      end else if (bus.instr_valid && p_valid) begin
        n_checks++; if (bus.instr !== p_instr || bus.pc_out !== p_pcout) begin n_fail++; $display("FAIL rnd_hold[%0d] got %h %h exp %h %h", i, bus.instr, bus.pc_out, p_instr, p_pcout); end
      end else if (bus.imem_req && p_req && !p_ack) begin
        n_checks++; if (bus.imem_addr !== p_addr) begin n_fail++; $display("FAIL rnd_addr_stable[%0d] got %h exp %h", i, bus.imem_addr, p_addr); end
      end
      rdy = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 9) == 0);
      bus.instr_ready = rdy;
      bus.branch_taken = br;
      bus.branch_target = $urandom;
      if (bus.instr_valid && rdy) begin
        n_checks++; if (bus.pc_out !== exp_pc || bus.instr !== mem_word(exp_pc) || bus.opcode !== bus.instr[31:26]) begin n_fail++; $display("FAIL rnd_deliver[%0d] got %h %h %h exp %h %h", i, bus.pc_out, bus.instr, bus.opcode, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (br) exp_pc = bus.branch_target & ~32'h3;
      p_valid = bus.instr_valid; p_req = bus.imem_req; p_ack = bus.imem_ack;
      p_hs = bus.instr_valid && rdy; p_br = br; p_target = bus.branch_target;
      p_instr = bus.instr; p_pcout = bus.pc_out; p_addr = bus.imem_addr;
    end
    n_checks++; if (delivered < 50) begin n_fail++; $display("FAIL rnd_progress got %0d exp >=50", delivered); end
  endtask

  initial begin
    rst = 1'b1;
    rst8 = 1'b1;
    busy = 1'b0;
    mem_const = 1'b0; mem_rand = 1'b0; mem_lat = 0; left = 0; req_addr = '0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    bus8.imem_ack = 1'b0; bus8.imem_rdata = '0; bus8.instr_ready = 1'b0;
    bus8.branch_taken = 1'b0; bus8.branch_target = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wait_states();
    test_redirect_wait();
    test_redirect_valid();
    test_wrap_and_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
